// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the logic-unit issuer: FSM states, opcodes
// and the packed command entry held in the command FIFO.
package logic_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESPOND
  } lu_state_e;

  localparam logic [2:0] LU_NOT_A = 3'b000;
  localparam logic [2:0] LU_NEG_B = 3'b001;
  localparam logic [2:0] LU_AND   = 3'b010;
  localparam logic [2:0] LU_XNOR  = 3'b011;
  localparam logic [2:0] LU_NAND  = 3'b100;
  localparam logic [2:0] LU_XOR   = 3'b101;
  localparam logic [2:0] LU_OR    = 3'b110;
  localparam logic [2:0] LU_NOR   = 3'b111;

  typedef struct packed {
    logic [2:0] sel;
    logic [1:0] a;
    logic [1:0] b;
    logic       chain;
  } lu_cmd_t;

endpackage

// File: rtl/lu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of lu_cmd_t; head entry is visible
// combinationally on rdata_o while the FIFO is non-empty.
module lu_cmd_fifo
  import logic_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  lu_cmd_t wdata_i,
  input  logic    pop_i,
  output lu_cmd_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  lu_cmd_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/logic_unit_issuer.sv
// Sequential front end for the 2-bit logic unit: queues commands, drives the
// unit one command at a time, samples its result after SETTLE cycles.
module logic_unit_issuer
  import logic_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_sel,
  input  logic [1:0] cmd_a,
  input  logic [1:0] cmd_b,
  input  logic       cmd_chain,
  output logic [1:0] lu_a,
  output logic [1:0] lu_b,
  output logic [2:0] lu_sel,
  input  logic [1:0] lu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_data,
  output logic [2:0] rsp_sel,
  output logic [7:0] op_count
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  lu_state_e   state_q,     state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [1:0]  lu_a_q,      lu_a_d;
  logic [1:0]  lu_b_q,      lu_b_d;
  logic [2:0]  lu_sel_q,    lu_sel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_data_q,  rsp_data_d;
  logic [2:0]  rsp_sel_q,   rsp_sel_d;
  logic [7:0]  op_count_q,  op_count_d;
  logic [1:0]  last_res_q,  last_res_d;

  lu_cmd_t     push_entry, head;
  logic        fifo_full, fifo_empty, fifo_pop;

  assign push_entry = '{sel: cmd_sel, a: cmd_a, b: cmd_b, chain: cmd_chain};
  assign cmd_ready  = !fifo_full;

  lu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    lu_sel_d    = lu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_sel_d   = rsp_sel_q;
    op_count_d  = op_count_q;
    last_res_d  = last_res_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          lu_sel_d = head.sel;
          lu_b_d   = head.b;
          // Chain resolves against the last captured result, never a queued one.
          lu_a_d   = head.chain ? last_res_q : head.a;
          cnt_d    = CW'(SETTLE - 1);
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_data_d  = lu_out;
          last_res_d  = lu_out;
          rsp_sel_d   = lu_sel_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      lu_sel_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sel_q   <= '0;
      op_count_q  <= '0;
      last_res_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      lu_sel_q    <= lu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sel_q   <= rsp_sel_d;
      op_count_q  <= op_count_d;
      last_res_q  <= last_res_d;
    end
  end

  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_sel    = lu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_sel   = rsp_sel_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_issuer.sv
// Bench for logic_unit_issuer: stubs the combinational logic unit, tracks
// accepted commands in a queue and checks every response against it.
module tb_logic_unit_issuer;
  import logic_unit_pkg::*;

  localparam int unsigned P_DEPTH  = 4;
  localparam int unsigned P_SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_chain;
  logic [2:0] cmd_sel;
  logic [1:0] cmd_a, cmd_b;
  logic [1:0] lu_a, lu_b, lu_out;
  logic [2:0] lu_sel;
  logic       rsp_valid, rsp_ready;
  logic [1:0] rsp_data;
  logic [2:0] rsp_sel;
  logic [7:0] op_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic [2:0] sel;
    logic [1:0] a_eff;
    logic [1:0] b;
    logic [1:0] res;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  model_last = 2'b00;
  int unsigned done_cnt   = 0;
  bit          spc_on     = 0;
  int unsigned spc_n      = 0;
  int unsigned last_hs    = 0;
  bit          prev_hold  = 0;
  logic [1:0]  prev_data  = 2'b00;

  function automatic logic [1:0] lu_ref(input logic [2:0] sel, input logic [1:0] a, input logic [1:0] b);
    case (sel)
      LU_NOT_A: return ~a;
      LU_NEG_B: return 2'd0 - b;
      LU_AND:   return a & b;
      LU_XNOR:  return ~(a ^ b);
      LU_NAND:  return ~(a & b);
      LU_XOR:   return a ^ b;
      LU_OR:    return a | b;
      default:  return ~(a | b);
    endcase
  endfunction

  assign lu_out = lu_ref(lu_sel, lu_a, lu_b);

  logic_unit_issuer #(.DEPTH(P_DEPTH), .SETTLE(P_SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_out(lu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_sel(rsp_sel), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Handshakes are sampled on the falling edge; inputs only move just after
  // the rising edge, so what is seen here is what the next rising edge takes.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check_val("rsp_hold_valid", rsp_valid, 1);
        check_val("rsp_hold_data", rsp_data, prev_data);
      end
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        e.sel   = cmd_sel;
        e.b     = cmd_b;
        e.a_eff = cmd_chain ? model_last : cmd_a;
        e.res   = lu_ref(e.sel, e.a_eff, e.b);
        model_last = e.res;
        exp_q.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_val("rsp_unexpected", rsp_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("rsp_data", rsp_data, e.res);
          check_val("rsp_sel", rsp_sel, e.sel);
          check_val("lu_a", lu_a, e.a_eff);
          check_val("lu_b", lu_b, e.b);
          check_val("lu_sel", lu_sel, e.sel);
          check_val("op_count", op_count, done_cnt % 256);
          done_cnt++;
        end
        if (spc_on) begin
          if (spc_n >= 2) check_val("spacing", cyc - last_hs, P_SETTLE + 2);
          spc_n++;
        end
        last_hs = cyc;
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
    end
  end

  task automatic rand_cmd();
    cmd_sel   = 3'($urandom);
    cmd_a     = 2'($urandom);
    cmd_b     = 2'($urandom);
    cmd_chain = ($urandom_range(0, 3) == 0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_cmd(input logic [2:0] s, input logic [1:0] a, input logic [1:0] b, input logic ch);
    bit acc = 0;
    cmd_valid = 1; cmd_sel = s; cmd_a = a; cmd_b = b; cmd_chain = ch;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk) acc = cmd_ready;
      @(posedge clk) #1;
    end
    cmd_valid = 0;
    check_val("push_accept", acc, 1);
  endtask

  task automatic drain();
    bit idle = 0;
    rsp_ready = 1;
    for (int i = 0; i < 2000 && !idle; i++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && !rsp_valid;
    end
    check_val("drain_done", idle, 1);
    @(posedge clk) #1;
  endtask

  task automatic check_reset_vals();
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_rsp_sel", rsp_sel, 0);
    check_val("rst_lu_a", lu_a, 0);
    check_val("rst_lu_b", lu_b, 0);
    check_val("rst_lu_sel", lu_sel, 0);
    check_val("rst_op_count", op_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, d0, nrsp;
    bit took;
    rst = 1; cmd_valid = 0; rsp_ready = 0;
    cmd_sel = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    @(posedge clk) #1 rst = 0;

    // Single op latency: accept at E, pop at E+1, response after E+2.
    push_cmd(LU_AND, 2'b11, 2'b01, 1'b0);
    @(negedge clk) check_val("lat_e0", rsp_valid, 0);
    @(negedge clk) check_val("lat_e1", rsp_valid, 0);
    check_val("load_lu_a", lu_a, 2'b11);
    check_val("load_lu_b", lu_b, 2'b01);
    check_val("load_lu_sel", lu_sel, LU_AND);
    @(negedge clk) check_val("lat_e2", rsp_valid, 1);
    check_val("single_data", rsp_data, 2'b01);
    check_val("single_sel", rsp_sel, LU_AND);
    @(posedge clk) #1;
    drain();
    check_val("single_count", op_count, 1);

    push_cmd(LU_NEG_B, 2'($urandom), 2'b01, 1'b0);
    push_cmd(LU_NEG_B, 2'($urandom), 2'b00, 1'b0);
    drain();

    push_cmd(LU_OR, 2'b01, 2'b10, 1'b0);
    push_cmd(LU_NOT_A, 2'b01, 2'($urandom), 1'b1);
    drain();

    // Backpressure: 7 commands offered while responses are stalled.
    d0 = done_cnt; acc = 0;
    rsp_ready = 0; cmd_valid = 1; rand_cmd();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) took = cmd_ready;
      @(posedge clk) #1;
      if (took) begin
        acc++;
        if (acc < 7) rand_cmd(); else cmd_valid = 0;
      end
    end
    check_val("bp_accepted", acc, 5);
    check_val("bp_cmd_ready", cmd_ready, 0);
    cmd_valid = 0;
    drain();
    check_val("bp_responses", done_cnt - d0, 5);

    // Random traffic with random backpressure.
    acc = 0;
    for (int i = 0; i < 3000 && acc < 60; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      rand_cmd();
      @(negedge clk) if (cmd_valid && cmd_ready) acc++;
      @(posedge clk) #1;
    end
    cmd_valid = 0;
    check_val("rand_accepted", acc, 60);
    drain();

    // Saturated stream up to the 256th response; spacing checked by the monitor.
    spc_on = 1; spc_n = 0; rsp_ready = 1; cmd_valid = 1; rand_cmd();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt >= 256) break;
      @(posedge clk) #1 rand_cmd();
    end
    check_val("wrap_reached", done_cnt, 256);
    @(negedge clk) check_val("wrap_op_count", op_count, 0);
    spc_on = 0;
    @(posedge clk) #1 cmd_valid = 0;
    drain();

    // Reset while a command settles and three more are queued.
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) push_cmd(3'($urandom), 2'($urandom), 2'($urandom), 1'b0);
    rsp_ready = 1;
    @(posedge clk) #1 rsp_ready = 0;
    @(posedge clk) #1 rst = 1;
    exp_q.delete(); model_last = 2'b00; done_cnt = 0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk) #1 rst = 0; rsp_ready = 1;
    nrsp = 0;
    for (int i = 0; i < 12; i++) @(negedge clk) if (rsp_valid) nrsp++;
    check_val("post_rst_rsp", nrsp, 0);
    @(posedge clk) #1;
    push_cmd(LU_NOT_A, 2'b01, 2'b00, 1'b1);
    drain();
    check_val("post_rst_count", op_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
